// File: rtl/feature_load_scheduler.sv
// feature_load_scheduler
//   Fetches one input feature map (one patch, or two patches for 16 channels)
//   from external memory in bursts and streams the returned beats into the
//   two feature-buffer FIFO banks. A burst is only requested after the target
//   bank reports room for a full burst, so returning data is never stalled.
//
// Ports
//   system_clk, rst             clock, asynchronous active-high reset
//   load_feature_begin          start pulse; latches feature_base_addr,
//                               patch_offset, row_size, col_size,
//                               feature_double_patch. Restarts if busy.
//   load_busy                   high from begin until finish
//   load_feature_finish         one-cycle done pulse
//   mem_rd_req_*/mem_rd_addr/   burst read request (len = beats - 1)
//   mem_rd_len
//   mem_rd_data(_valid)         returned beats, no backpressure
//   feature_data                registered beat to the buffer
//   feature_buffer_{1,2}_valid  per-bank write strobe
//   feature_buffer_{1,2}_ready  bank can absorb a full burst
//   stall_cycles                cycles waiting on a not-ready bank
//
// Optional feature macro: FEATURE_LOAD_PERF_CNT_EN enables stall_cycles;
// when undefined the counter is absent and stall_cycles is tied to 0.

module feature_load_scheduler #(
    parameter int MEM_DATA_WIDTH = 512,
    parameter int ADDR_WIDTH     = 32,
    parameter int BURST_LEN      = 64,
    parameter int BEAT_BYTES     = MEM_DATA_WIDTH / 8
) (
    input  logic                      system_clk,
    input  logic                      rst,
    input  logic                      load_feature_begin,
    input  logic [ADDR_WIDTH-1:0]     feature_base_addr,
    input  logic [ADDR_WIDTH-1:0]     patch_offset,
    input  logic [9:0]                row_size,
    input  logic [9:0]                col_size,
    input  logic                      feature_double_patch,
    output logic                      load_busy,
    output logic                      load_feature_finish,
    output logic                      mem_rd_req_valid,
    input  logic                      mem_rd_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
    output logic [7:0]                mem_rd_len,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
    input  logic                      mem_rd_data_valid,
    output logic [MEM_DATA_WIDTH-1:0] feature_data,
    output logic                      feature_buffer_1_valid,
    output logic                      feature_buffer_2_valid,
    input  logic                      feature_buffer_1_ready,
    input  logic                      feature_buffer_2_ready,
    output logic [31:0]               stall_cycles
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_REQ      = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] CHUNK_BYTES = ADDR_WIDTH'(BURST_LEN * BEAT_BYTES);
    localparam logic [17:0]           BURST_BEATS = 18'(BURST_LEN);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] offset_q;
    logic [ADDR_WIDTH-1:0] chunk_off_q;   // byte offset of the current chunk
    logic                  double_q;
    logic                  target_q;      // 0 = patch 1 / bank 1, 1 = patch 2 / bank 2
    logic [17:0]           beats_left_q;  // beats from the current chunk to the end of a patch
    logic [8:0]            outstanding_q; // up to 256 beats of the in-flight burst

    logic [19:0] pixels;
    logic [19:0] pixels_rnd;
    logic [17:0] total_beats;
    logic [17:0] cur_len;
    logic [8:0]  outstanding_nxt;
    logic        target_ready;
    logic        burst_live;

    // 4 pixels per beat, rounded up; the max map (1023x1023) fits in 18 bits
    assign pixels      = {10'd0, row_size} * {10'd0, col_size};
    assign pixels_rnd  = pixels + 20'd3;
    assign total_beats = 18'(pixels_rnd >> 2);

    assign cur_len         = (beats_left_q > BURST_BEATS) ? BURST_BEATS : beats_left_q;
    assign outstanding_nxt = outstanding_q - {8'd0, mem_rd_data_valid};
    assign target_ready    = target_q ? feature_buffer_2_ready : feature_buffer_1_ready;

    // Memory still owes beats after this cycle: a request is being accepted
    // right now, or a burst is in flight and this cycle's beat is not its last.
    assign burst_live = (state == S_REQ && mem_rd_req_ready) ||
                        ((state == S_DATA || state == S_DRAIN) && outstanding_nxt != 9'd0);

    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            state                  <= S_IDLE;
            base_q                 <= '0;
            offset_q               <= '0;
            chunk_off_q            <= '0;
            double_q               <= 1'b0;
            target_q               <= 1'b0;
            beats_left_q           <= '0;
            outstanding_q          <= '0;
            load_busy              <= 1'b0;
            load_feature_finish    <= 1'b0;
            mem_rd_req_valid       <= 1'b0;
            mem_rd_addr            <= '0;
            mem_rd_len             <= '0;
            feature_data           <= '0;
            feature_buffer_1_valid <= 1'b0;
            feature_buffer_2_valid <= 1'b0;
        end else begin
            load_feature_finish <= 1'b0;

            // Strobes only for beats of a live burst; a drained burst writes nothing.
            feature_data           <= mem_rd_data;
            feature_buffer_1_valid <= mem_rd_data_valid && state == S_DATA && !target_q;
            feature_buffer_2_valid <= mem_rd_data_valid && state == S_DATA && target_q;

            if (load_feature_begin) begin
                // Fresh start or restart: any in-flight burst is drained silently.
                base_q           <= feature_base_addr;
                offset_q         <= patch_offset;
                double_q         <= feature_double_patch;
                beats_left_q     <= total_beats;
                chunk_off_q      <= '0;
                target_q         <= 1'b0;
                load_busy        <= 1'b1;
                mem_rd_req_valid <= 1'b0;
                if (burst_live) begin
                    state         <= S_DRAIN;
                    outstanding_q <= (state == S_REQ) ? ({1'b0, mem_rd_len} + 9'd1)
                                                      : outstanding_nxt;
                end else begin
                    state <= (total_beats == 18'd0) ? S_DONE : S_WAIT_RDY;
                end
            end else begin
                case (state)
                    S_WAIT_RDY: begin
                        if (target_ready) begin
                            mem_rd_req_valid <= 1'b1;
                            mem_rd_addr      <= base_q + chunk_off_q + (target_q ? offset_q : '0);
                            mem_rd_len       <= 8'(cur_len - 18'd1);
                            state            <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (mem_rd_req_ready) begin
                            mem_rd_req_valid <= 1'b0;
                            outstanding_q    <= {1'b0, mem_rd_len} + 9'd1;
                            state            <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (mem_rd_data_valid) begin
                            outstanding_q <= outstanding_nxt;
                            if (outstanding_nxt == 9'd0) begin
                                if (!target_q && double_q) begin
                                    // same chunk, second patch
                                    target_q <= 1'b1;
                                    state    <= S_WAIT_RDY;
                                end else begin
                                    target_q     <= 1'b0;
                                    beats_left_q <= beats_left_q - cur_len;
                                    chunk_off_q  <= chunk_off_q + CHUNK_BYTES;
                                    state        <= (beats_left_q == cur_len) ? S_DONE : S_WAIT_RDY;
                                end
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (mem_rd_data_valid) begin
                            outstanding_q <= outstanding_nxt;
                            if (outstanding_nxt == 9'd0)
                                state <= (beats_left_q == 18'd0) ? S_DONE : S_WAIT_RDY;
                        end
                    end
                    S_DONE: begin
                        load_feature_finish <= 1'b1;
                        load_busy           <= 1'b0;
                        state               <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef FEATURE_LOAD_PERF_CNT_EN
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (load_feature_begin)
            stall_cycles <= '0;
        else if (state == S_WAIT_RDY && !target_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_feature_load_scheduler.sv
module tb_feature_load_scheduler;
    localparam int DW = 512;
    localparam int AW = 32;
    localparam int BL = 64;          // beats per full burst
    localparam int CHUNK = BL * (DW / 8);

    typedef struct packed { logic bank; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; logic bank; } rq_t;

    logic          system_clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_feature_begin = 1'b0;
    logic [AW-1:0] feature_base_addr = '0;
    logic [AW-1:0] patch_offset = '0;
    logic [9:0]    row_size = '0;
    logic [9:0]    col_size = '0;
    logic          feature_double_patch = 1'b0;
    logic          load_busy, load_feature_finish;
    logic          mem_rd_req_valid;
    logic          mem_rd_req_ready = 1'b0;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_len;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_rd_data_valid = 1'b0;
    logic [DW-1:0] feature_data;
    logic          feature_buffer_1_valid, feature_buffer_2_valid;
    logic          feature_buffer_1_ready = 1'b1;
    logic          feature_buffer_2_ready = 1'b1;
    logic [31:0]   stall_cycles;

    always #5 system_clk = ~system_clk;

    feature_load_scheduler dut (
        .system_clk(system_clk), .rst(rst),
        .load_feature_begin(load_feature_begin), .feature_base_addr(feature_base_addr),
        .patch_offset(patch_offset), .row_size(row_size), .col_size(col_size),
        .feature_double_patch(feature_double_patch),
        .load_busy(load_busy), .load_feature_finish(load_feature_finish),
        .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_ready(mem_rd_req_ready),
        .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
        .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid),
        .feature_data(feature_data),
        .feature_buffer_1_valid(feature_buffer_1_valid), .feature_buffer_2_valid(feature_buffer_2_valid),
        .feature_buffer_1_ready(feature_buffer_1_ready), .feature_buffer_2_ready(feature_buffer_2_ready),
        .stall_cycles(stall_cycles)
    );

    int checks = 0;
    int failures = 0;

    wr_t wr_q[$];   // expected bank writes
    rq_t req_q[$];  // expected burst requests

    int cyc = 0, begin_cyc = -100, last_strobe_cyc = 0, fin_cnt = 0;
    int mem_pend = 0, hold_cnt = 0;
    bit mem_bank = 0, mem_drop = 0, hold_arm = 0, gap_en = 1, no_data = 0, fin_mode = 0;
    bit bgn_go = 0, bgn_dbl = 0;
    logic [AW-1:0] bgn_base = '0, bgn_off = '0;
    int bgn_rows = 0, bgn_cols = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected request sequence: chunk-major, patch 1 then patch 2.
    task automatic plan(input logic [AW-1:0] base, input logic [AW-1:0] off,
                        input int rows, input int cols, input bit dbl);
        int total, n;
        total = (rows * cols + 3) / 4;
        for (int k = 0; k * BL < total; k++) begin
            n = total - k * BL;
            if (n > BL) n = BL;
            req_q.push_back('{base + AW'(k * CHUNK), 8'(n - 1), 1'b0});
            if (dbl) req_q.push_back('{base + off + AW'(k * CHUNK), 8'(n - 1), 1'b1});
        end
    endtask

    // One clock: sample DUT at the negedge, then drive the memory model and inputs.
    task automatic step();
        wr_t w;
        rq_t r;
        logic [DW-1:0] d;
        bit rdy;
        @(negedge system_clk);
        cyc++;
        if (feature_buffer_1_valid || feature_buffer_2_valid) begin
            check("one_bank_strobe", DW'(feature_buffer_1_valid & feature_buffer_2_valid), '0);
            if (wr_q.size() == 0)
                check("unexpected_strobe", DW'(feature_buffer_1_valid | feature_buffer_2_valid), '0);
            else begin
                w = wr_q.pop_front();
                check("strobe_bank", DW'(feature_buffer_2_valid), DW'(w.bank));
                check("strobe_data", feature_data, w.data);
            end
            last_strobe_cyc = cyc;
        end
        if (load_feature_finish) begin
            fin_cnt++;
            if (fin_mode) check("finish_latency_empty", DW'(cyc - begin_cyc), DW'(2));
            else          check("finish_after_strobe", DW'(cyc - last_strobe_cyc), DW'(1));
            check("busy_clear", DW'(load_busy), '0);
        end
        if (cyc == begin_cyc + 1) check("busy_set", DW'(load_busy), DW'(1));
        if (hold_cnt > 0) check("no_req_during_hold", DW'(mem_rd_req_valid), '0);

        load_feature_begin     = 1'b0;
        feature_buffer_2_ready = !(hold_arm || hold_cnt > 0);
        if (hold_cnt > 0) hold_cnt--;

        mem_rd_data_valid = 1'b0;
        if (mem_pend > 0 && !no_data && !(gap_en && $urandom_range(0, 3) == 0)) begin
            d = rand_beat();
            mem_rd_data = d;
            mem_rd_data_valid = 1'b1;
            mem_pend--;
            if (!mem_drop) wr_q.push_back('{mem_bank, d});
            if (mem_pend == 0 && hold_arm && !mem_drop) begin
                hold_arm = 0;
                hold_cnt = 20;
            end
        end
        no_data = 0;

        rdy = ($urandom_range(0, 3) != 0);
        mem_rd_req_ready = rdy;
        if (mem_rd_req_valid && rdy) begin
            check("single_outstanding", DW'(mem_pend), '0);
            if (req_q.size() == 0)
                check("unexpected_req", DW'(mem_rd_req_valid), '0);
            else begin
                r = req_q.pop_front();
                check("req_addr", DW'(mem_rd_addr), DW'(r.addr));
                check("req_len", DW'(mem_rd_len), DW'(r.len));
                mem_bank = r.bank;
            end
            mem_pend = int'(mem_rd_len) + 1;
            mem_drop = 0;
        end

        if (bgn_go) begin
            load_feature_begin   = 1'b1;
            feature_base_addr    = bgn_base;
            patch_offset         = bgn_off;
            row_size             = 10'(bgn_rows);
            col_size             = 10'(bgn_cols);
            feature_double_patch = bgn_dbl;
            req_q.delete();
            plan(bgn_base, bgn_off, bgn_rows, bgn_cols, bgn_dbl);
            mem_drop  = 1;   // anything still owed belongs to the old load
            begin_cyc = cyc;
            bgn_go    = 0;
        end
    endtask

    task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] off,
                         input int rows, input int cols, input bit dbl);
        bgn_base = base; bgn_off = off; bgn_rows = rows; bgn_cols = cols; bgn_dbl = dbl;
        bgn_go = 1;
        step();
    endtask

    task automatic run_until_done(input string tag, input int exp_fin);
        int n;
        n = 0;
        while (!(fin_cnt >= exp_fin && wr_q.size() == 0 && req_q.size() == 0 && mem_pend == 0)
               && n < 4000) begin
            step();
            n++;
        end
        check({tag, "_in_budget"}, DW'(n < 4000), DW'(1));
        repeat (6) step();
        check({tag, "_finish_count"}, DW'(fin_cnt), DW'(exp_fin));
        check({tag, "_writes_left"}, DW'(wr_q.size()), '0);
        check({tag, "_reqs_left"}, DW'(req_q.size()), '0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, DW'(load_busy), '0);
        check({tag, "_finish"}, DW'(load_feature_finish), '0);
        check({tag, "_req_valid"}, DW'(mem_rd_req_valid), '0);
        check({tag, "_addr"}, DW'(mem_rd_addr), '0);
        check({tag, "_len"}, DW'(mem_rd_len), '0);
        check({tag, "_data"}, feature_data, '0);
        check({tag, "_fb_valid"}, DW'({feature_buffer_1_valid, feature_buffer_2_valid}), '0);
        check({tag, "_stall"}, DW'(stall_cycles), '0);
    endtask

    task automatic new_test(input bit mode);
        fin_cnt = 0;
        fin_mode = mode;
        gap_en = 1;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge system_clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (2) step();

        // single 4x4: one request 0x1000 len 3, four bank-1 writes
        new_test(0);
        start(32'h0000_1000, '0, 4, 4, 0);
        run_until_done("single4x4", 1);

        // double 32x32: 8 interleaved requests, 256 writes per bank
        new_test(0);
        start(32'h0000_0000, 32'h0001_0000, 32, 32, 1);
        run_until_done("double32", 1);

        // odd 3x3: one request len 2
        new_test(0);
        start(32'h2000_0040, '0, 3, 3, 0);
        run_until_done("odd3x3", 1);

        // address wrap across 2^32
        new_test(0);
        start(32'hFFFF_E000, '0, 32, 32, 0);
        run_until_done("wrap", 1);

        // bank 2 held not-ready for 20 cycles after the patch-1 burst
        new_test(0);
        hold_arm = 1;
        start(32'h0000_3000, 32'h0000_0800, 4, 4, 1);
        run_until_done("hold", 1);
`ifdef FEATURE_LOAD_PERF_CNT_EN
        check("stall_cycles", DW'(stall_cycles), DW'(20));
`else
        check("stall_cycles", DW'(stall_cycles), '0);
`endif

        // abort mid-burst with 10 beats owed: they are drained, new load runs
        new_test(0);
        start(32'h0000_4000, '0, 32, 32, 0);
        n = 0;
        while (mem_pend != 10 && n < 2000) begin step(); n++; end
        check("abort_point_reached", DW'(mem_pend), DW'(10));
        no_data = 1;
        start(32'h0000_9000, '0, 4, 4, 0);
        run_until_done("abort", 1);

        // begin in the same cycle as the final beat: beat written, no finish for old load
        new_test(0);
        start(32'h0000_5000, '0, 3, 3, 0);
        n = 0;
        while (mem_pend != 1 && n < 2000) begin step(); n++; end
        check("last_beat_point_reached", DW'(mem_pend), DW'(1));
        gap_en = 0;
        start(32'h0000_A000, '0, 4, 4, 0);
        run_until_done("begin_on_last", 1);

        // empty map: no request, finish two cycles after begin
        new_test(1);
        start(32'h0000_6000, '0, 0, 5, 1);
        run_until_done("empty", 1);

        // asynchronous reset in the middle of a burst
        new_test(0);
        start(32'h0000_7000, '0, 32, 32, 0);
        n = 0;
        while (mem_pend != 30 && n < 2000) begin step(); n++; end
        check("reset_point_reached", DW'(mem_pend), DW'(30));
        @(negedge system_clk);
        rst = 1'b1;
        mem_rd_data_valid = 1'b0;
        #1;
        check_zero_outputs("rst_mid");
        mem_pend = 0; hold_cnt = 0; hold_arm = 0;
        wr_q.delete();
        req_q.delete();
        repeat (2) @(negedge system_clk);
        rst = 1'b0;
        repeat (2) step();

        // recovery after reset
        new_test(0);
        start(32'h0000_8000, '0, 3, 3, 0);
        run_until_done("after_reset", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog");
    end
endmodule
